mac_arbiter: RTL

//  Shares one multiply_add_64x64 datapath (o = a*b + c, registered) among NREQ requesters.

---
 rtl/mac_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mac_arbiter
// Description : Round-robin front end for one shared multiply-add datapath
//               (o = a*b + c, registered). Accepts one request at a time,
//               drives and holds the MAC operands, waits out the MAC latency,
//               captures the result and returns it with the requester id over
//               a valid/ready response channel.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               req_valid/req_ready      - per-requester handshake (ready one-hot)
//               req_a/req_b/req_c        - packed per-requester operands
//               mac_a/mac_b/mac_c/mac_o  - connection to the shared MAC
//               rsp_valid/rsp_ready      - response handshake
//               rsp_id/rsp_o             - owner index and result
//               busy                     - high whenever an op is in progress
//               ops_done                 - completed responses, wraps at 2^32
// Revision    : 1.0 - initial release
// ============================================================================
module mac_arbiter #(
    parameter int BITS    = 64,
    parameter int NREQ    = 4,
    parameter int MAC_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*BITS-1:0]       req_a,
    input  logic [NREQ*BITS-1:0]       req_b,
    input  logic [NREQ*2*BITS-1:0]     req_c,
    output logic [BITS-1:0]            mac_a,
    output logic [BITS-1:0]            mac_b,
    output logic [2*BITS-1:0]          mac_c,
    input  logic [2*BITS-1:0]          mac_o,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [2*BITS-1:0]          rsp_o,
    output logic                       busy,
    output logic [31:0]                ops_done
);

    localparam int c_IDW  = $clog2(NREQ);
    localparam int c_CNTW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [c_IDW-1:0]    r_last;
    logic [c_IDW-1:0]    r_id;
    logic [c_CNTW-1:0]   r_cnt;
    logic [BITS-1:0]     r_mac_a;
    logic [BITS-1:0]     r_mac_b;
    logic [2*BITS-1:0]   r_mac_c;
    logic                r_rsp_valid;
    logic [c_IDW-1:0]    r_rsp_id;
    logic [2*BITS-1:0]   r_rsp_o;
    logic [31:0]         r_ops_done;

    logic                w_gnt_vld;
    logic [c_IDW-1:0]    w_gnt_idx;
    logic [NREQ-1:0]     w_ready;

    // Round-robin search starting just after the last grant. The loop runs
    // from the farthest candidate back to the nearest so the nearest valid
    // requester is the final (winning) assignment.
    always_comb begin
        logic [c_IDW-1:0] v_idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            v_idx = c_IDW'((int'(r_last) + k) % NREQ);
            if (req_valid[v_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
    end

    // Ready is only offered while idle, so at most one requester sees it.
    always_comb begin
        w_ready = '0;
        if (r_state == c_ST_IDLE && w_gnt_vld) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_last      <= c_IDW'(NREQ - 1);  // requester 0 wins first
            r_id        <= '0;
            r_cnt       <= '0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_c     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_o     <= '0;
            r_ops_done  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_mac_a <= req_a[w_gnt_idx*BITS +: BITS];
                        r_mac_b <= req_b[w_gnt_idx*BITS +: BITS];
                        r_mac_c <= req_c[w_gnt_idx*2*BITS +: 2*BITS];
                        r_id    <= w_gnt_idx;
                        r_last  <= w_gnt_idx;
                        r_cnt   <= c_CNTW'(MAC_LAT);
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    // Operands stay untouched here so the MAC sees them
                    // stable for its whole latency.
                    if (r_cnt == '0) begin
                        r_rsp_o     <= mac_o;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_CNTW'(1);
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 32'd1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign mac_a     = r_mac_a;
    assign mac_b     = r_mac_b;
    assign mac_c     = r_mac_c;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_o     = r_rsp_o;
    assign busy      = (r_state != c_ST_IDLE);
    assign ops_done  = r_ops_done;

endmodule
`default_nettype wire
